// File: rtl/fp24_inv_sqrt_arbiter_pkg.sv
// rtl/fp24_inv_sqrt_arbiter_pkg.sv - fp24 type, constants and round-robin helper
package fp24_inv_sqrt_arbiter_pkg;

    // fp24: 1 sign, 7 exponent (bias 63), 16 mantissa
    typedef logic [23:0] fp24_t;

    localparam int    FP24_W    = 24;
    localparam fp24_t FP24_ONE  = 24'h3f0000;
    localparam fp24_t FP24_FOUR = 24'h410000;
    localparam fp24_t FP24_HALF = 24'h3e0000;

    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/fp24_inv_sqrt_arbiter_if.sv
// rtl/fp24_inv_sqrt_arbiter_if.sv - requester-side request/result bundle
interface fp24_inv_sqrt_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int USER_W  = 8
);
    logic [NUM_REQ*24-1:0]     req_x;
    logic [NUM_REQ*USER_W-1:0] req_user;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*24-1:0]     res_y;
    logic [NUM_REQ*USER_W-1:0] res_user;
    logic [NUM_REQ-1:0]        res_valid;

    modport master (
        output req_x, req_user, req_valid,
        input  req_ready, res_y, res_user, res_valid
    );

    modport slave (
        input  req_x, req_user, req_valid,
        output req_ready, res_y, res_user, res_valid
    );
endinterface

// File: rtl/fp24_inv_sqrt_arbiter_rr_arbiter.sv
// rtl/fp24_inv_sqrt_arbiter_rr_arbiter.sv - combinational round-robin grant from a pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [IDX_W-1:0] cand;

    // Scan from the pointer upward, wrapping; the first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any_grant && valid[cand]) begin
                any_grant   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp24_inv_sqrt_arbiter.sv
// rtl/fp24_inv_sqrt_arbiter.sv - shares one pipelined fp24 inverse-sqrt unit among requesters
module fp24_inv_sqrt_arbiter
    import fp24_inv_sqrt_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int UNIT_LATENCY = 4,
    parameter int USER_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fp24_inv_sqrt_arbiter_if.slave   req_if,
    output fp24_t                    unit_x,
    output logic                     unit_x_valid,
    output logic                     unit_rst,
    input  fp24_t                    unit_result,
    input  logic                     unit_result_valid,
    output logic                     err_sticky
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]                     rst_sync;
    logic [IDX_W-1:0]               rr_ptr;
    logic [IDX_W-1:0]               grant_idx;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             arb_valid;
    logic                           any_grant;

    logic [NUM_REQ-1:0][FP24_W-1:0] req_x_arr;
    logic [NUM_REQ-1:0][USER_W-1:0] req_user_arr;

    logic [IDX_W-1:0]               issue_id;
    logic [USER_W-1:0]              issue_user;

    logic [UNIT_LATENCY-1:0]        tag_valid;
    logic [IDX_W-1:0]               tag_id   [UNIT_LATENCY];
    logic [USER_W-1:0]              tag_user [UNIT_LATENCY];

    logic                           head_valid;
    logic [IDX_W-1:0]               head_id;
    logic [USER_W-1:0]              head_user;

    logic [NUM_REQ-1:0][FP24_W-1:0] res_y_q;
    logic [NUM_REQ-1:0][USER_W-1:0] res_user_q;
    logic [NUM_REQ-1:0]             res_valid_q;

    assign req_x_arr    = req_if.req_x;
    assign req_user_arr = req_if.req_user;

    // Unit reset asserts with rst_n and releases two clocks after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign unit_rst  = rst_sync[1];
    assign arb_valid = unit_rst ? '0 : req_if.req_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .valid     (arb_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_if.req_ready = grant;

    // Issue register: drives the unit and also acts as the tag push stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_x       <= '0;
            unit_x_valid <= 1'b0;
            issue_id     <= '0;
            issue_user   <= '0;
            rr_ptr       <= '0;
        end else begin
            unit_x_valid <= any_grant;
            if (any_grant) begin
                unit_x     <= req_x_arr[grant_idx];
                issue_id   <= grant_idx;
                issue_user <= req_user_arr[grant_idx];
                rr_ptr     <= IDX_W'(rr_wrap_inc(32'(grant_idx), NUM_REQ));
            end
        end
    end

    // Stage 0 loads from the issue register, so the head lines up with unit output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            for (int i = 0; i < UNIT_LATENCY; i++) begin
                tag_id[i]   <= '0;
                tag_user[i] <= '0;
            end
        end else begin
            tag_valid[0] <= unit_x_valid;
            tag_id[0]    <= issue_id;
            tag_user[0]  <= issue_user;
            for (int i = 1; i < UNIT_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
                tag_user[i]  <= tag_user[i-1];
            end
        end
    end

    assign head_valid = tag_valid[UNIT_LATENCY-1];
    assign head_id    = tag_id[UNIT_LATENCY-1];
    assign head_user  = tag_user[UNIT_LATENCY-1];

    // Orphan results and missing results are both dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_y_q     <= '0;
            res_user_q  <= '0;
            res_valid_q <= '0;
            err_sticky  <= 1'b0;
        end else begin
            res_valid_q <= '0;
            if (head_valid && unit_result_valid) begin
                res_valid_q[head_id] <= 1'b1;
                res_y_q[head_id]     <= unit_result;
                res_user_q[head_id]  <= head_user;
            end
            if (head_valid != unit_result_valid) begin
                err_sticky <= 1'b1;
            end
        end
    end

    assign req_if.res_y     = res_y_q;
    assign req_if.res_user  = res_user_q;
    assign req_if.res_valid = res_valid_q;

endmodule

// File: tb/tb_fp24_inv_sqrt_arbiter.sv
// tb/tb_fp24_inv_sqrt_arbiter.sv - scoreboard bench with a behavioural inverse-sqrt unit
module tb_fp24_inv_sqrt_arbiter;
    import fp24_inv_sqrt_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 4;
    localparam int UW  = 8;

    logic        clk;
    logic        rst_n;
    logic [23:0] unit_x;
    logic        unit_x_valid;
    logic        unit_rst;
    logic [23:0] unit_result;
    logic        unit_result_valid;
    logic        err_sticky;
    logic        force_spurious;

    fp24_inv_sqrt_arbiter_if #(.NUM_REQ(N), .USER_W(UW)) bus ();

    fp24_inv_sqrt_arbiter #(.NUM_REQ(N), .UNIT_LATENCY(LAT), .USER_W(UW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_if            (bus),
        .unit_x            (unit_x),
        .unit_x_valid      (unit_x_valid),
        .unit_rst          (unit_rst),
        .unit_result       (unit_result),
        .unit_result_valid (unit_result_valid),
        .err_sticky        (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int res_count = 0;

    typedef struct {
        int          id;
        logic [7:0]  user;
        logic [23:0] y;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_log[$];
    logic [23:0] drv_exp [N];

    always @(posedge clk) cyc <= cyc + 1;

    // Inverse-sqrt unit model: decode, compute in real, re-encode.
    function automatic logic [23:0] ref_inv_sqrt(input logic [23:0] x);
        real v;
        real r;
        int  e;
        int  m;
        if (x[23] || x[22:16] == 7'd0) return 24'h7fffff;
        v = 1.0 + real'(x[15:0]) / 65536.0;
        e = int'(x[22:16]) - 63;
        while (e > 0) begin v = v * 2.0; e = e - 1; end
        while (e < 0) begin v = v / 2.0; e = e + 1; end
        r = 1.0 / $sqrt(v);
        e = 63;
        while (r >= 2.0) begin r = r / 2.0; e = e + 1; end
        while (r < 1.0)  begin r = r * 2.0; e = e - 1; end
        m = int'((r - 1.0) * 65536.0);
        if (m > 65535) begin m = 0; e = e + 1; end
        return {1'b0, e[6:0], m[15:0]};
    endfunction

    logic [LAT-1:0] mdl_v;
    logic [23:0]    mdl_y [LAT];

    always @(posedge clk) begin
        if (unit_rst) begin
            mdl_v <= '0;
        end else begin
            mdl_v    <= {mdl_v[LAT-2:0], unit_x_valid};
            mdl_y[0] <= ref_inv_sqrt(unit_x);
            for (int i = 1; i < LAT; i++) mdl_y[i] <= mdl_y[i-1];
        end
    end

    assign unit_result       = mdl_y[LAT-1];
    assign unit_result_valid = mdl_v[LAT-1] | force_spurious;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        int d;
        d = int'(obs) - int'(exp);
        if (d < 0) d = -d;
        checks++;
        assert (d <= 2) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h within 2 ulp", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on result.
    always @(negedge clk) begin
        exp_t e;
        int   rid;
        check("ready_rule", ((bus.req_ready & ~bus.req_valid) == '0) && $onehot0(bus.req_ready), 1);
        for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                e.id   = i;
                e.user = bus.req_user[i*UW +: UW];
                e.y    = drv_exp[i];
                e.due  = cyc + 6;
                exp_q.push_back(e);
                grant_log.push_back(i);
            end
        end
        if (bus.res_valid != '0) begin
            check("res_onehot", $onehot(bus.res_valid), 1);
            if (exp_q.size() == 0) begin
                check("res_unexpected", bus.res_valid, 0);
            end else begin
                e = exp_q.pop_front();
                rid = 0;
                for (int i = 0; i < N; i++) if (bus.res_valid[i]) rid = i;
                check("res_id", rid, e.id);
                check("res_user", bus.res_user[rid*UW +: UW], e.user);
                check_near("res_y", bus.res_y[rid*24 +: 24], e.y);
                check("res_latency", cyc, e.due);
                res_count++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [23:0] x, input logic [7:0] u, input logic [23:0] ey);
        bus.req_x[i*24 +: 24]  = x;
        bus.req_user[i*UW +: UW] = u;
        drv_exp[i] = ey;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain", exp_q.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [23:0] x_tab [4];
    logic [23:0] y_tab [4];
    int          rc0;

    initial begin
        x_tab[0] = FP24_FOUR;  y_tab[0] = FP24_HALF;
        x_tab[1] = FP24_ONE;   y_tab[1] = FP24_ONE;
        x_tab[2] = 24'h400000; y_tab[2] = 24'h3e6a0a;
        x_tab[3] = 24'h430000; y_tab[3] = 24'h3d0000;

        rst_n = 1'b0;
        force_spurious = 1'b0;
        bus.req_x = '0;
        bus.req_user = '0;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) drv_exp[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_y", bus.res_y, 0);
        check("rst_unit_x_valid", unit_x_valid, 0);
        check("rst_unit_x", unit_x, 0);
        check("rst_err", err_sticky, 0);
        check("rst_unit_rst", unit_rst, 1);

        rst_n = 1'b1;
        tick();
        check("unit_rst_hold", unit_rst, 1);
        tick();
        check("unit_rst_release", unit_rst, 0);

        // Requesters 1 and 3 only, pointer at 0
        for (int i = 0; i < N; i++) set_req(i, FP24_FOUR, 8'h10 + 8'(i), FP24_HALF);
        grant_log.delete();
        bus.req_valid = 4'b1010;
        repeat (4) tick();
        bus.req_valid = '0;
        check("alt_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("alt_g0", grant_log[0], 1);
            check("alt_g1", grant_log[1], 3);
            check("alt_g2", grant_log[2], 1);
            check("alt_g3", grant_log[3], 3);
        end
        wait_drain();

        // All requesters valid: fair rotation
        for (int i = 0; i < N; i++) set_req(i, FP24_ONE, 8'(i), FP24_ONE);
        grant_log.delete();
        bus.req_valid = 4'b1111;
        repeat (8) tick();
        bus.req_valid = '0;
        check("rot_count", grant_log.size(), 8);
        if (grant_log.size() == 8) begin
            for (int k = 0; k < 8; k++) check("rot_order", grant_log[k], k % N);
        end
        wait_drain();

        // Single request from requester 2
        set_req(2, FP24_FOUR, 8'hA5, FP24_HALF);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("single_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        wait_drain();
        check_near("single_hold_y", bus.res_y[2*24 +: 24], FP24_HALF);
        check("single_hold_user", bus.res_user[2*UW +: UW], 8'hA5);

        // Back-to-back issue with a return landing on a grant cycle
        rc0 = res_count;
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            set_req(0, x_tab[c % 4], 8'h40 + 8'(c), y_tab[c % 4]);
            @(negedge clk);
            if (c == 6) begin
                check("b2b_grant", bus.req_ready, 4'b0001);
                check("b2b_return", bus.res_valid, 4'b0001);
            end
            tick();
        end
        bus.req_valid = '0;
        wait_drain();
        check("b2b_results", res_count - rc0, 7);
        check("err_clean", err_sticky, 0);

        // Reset while three operations are in flight
        for (int i = 0; i < 3; i++) set_req(i, FP24_ONE, 8'h80 + 8'(i), FP24_ONE);
        bus.req_valid = 4'b0111;
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_req_ready", bus.req_ready, 0);
        check("mid_res_valid", bus.res_valid, 0);
        check("mid_unit_x_valid", unit_x_valid, 0);
        check("mid_unit_x", unit_x, 0);
        check("mid_unit_rst", unit_rst, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_nogrant0", bus.req_ready, 0);
        tick();
        @(negedge clk);
        check("mid_nogrant1", bus.req_ready, 0);
        tick();
        @(negedge clk);
        check("mid_first_grant", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        wait_drain();
        check("mid_err", err_sticky, 0);

        // Orphan unit result with an empty pipeline head
        force_spurious = 1'b1;
        tick();
        force_spurious = 1'b0;
        check("err_set", err_sticky, 1);
        @(negedge clk);
        check("err_no_res", bus.res_valid, 0);
        repeat (3) tick();
        check("err_hold", err_sticky, 1);
        rst_n = 1'b0;
        #1;
        check("err_clear", err_sticky, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
